button_conditioner: RTL
=======================

Name: button_conditioner

Overview:
- Front-end input stage that sits directly upstream of the calculator control FSM.
- Takes raw board push-buttons (next, clear) and the 3-bit mode switch bank, all asynchronous and bouncy.
- Synchronises and debounces them, then produces clean single-cycle pulses and a stable mode value in the CLK domain.
- Outputs drive the FSM's next, clear and MS inputs directly, so the FSM sees exactly one event per physical press.

Parameters:
DB_CYCLES, 1000000, consecutive stable cycles required to accept a level change (10 ms at 100 MHz); legal range >= 2
CNT_W, $clog2(DB_CYCLES), width of each debounce counter; derived, not overridden

Ports:
CLK  input  1  system clock, all logic on rising edge
clear_n  input  1  reset, asynchronous, active-low
btn_next_raw  input  1  raw "next" push-button, active-high, asynchronous
btn_clear_raw  input  1  raw "clear" push-button, active-high, asynchronous
sw_ms_raw  input  3  raw mode switches, asynchronous
next_pulse  output  1  one-cycle pulse per accepted press of next
clear_pulse  output  1  one-cycle pulse per accepted press of clear
next_level  output  1  debounced level of next button (for LED)
MS_db  output  3  debounced, stable mode select

Behaviour:
- Reset (clear_n low, asynchronous): all sync flops 0; all counters 0; both button FSMs IDLE; next_pulse = clear_pulse = next_level = 0; MS_db = 3'b000. Outputs stay at these values until after the first rising CLK edge with clear_n high.
- Synchroniser: every raw input passes through 2 flops. The sync value equals raw as sampled 2 edges earlier. All following logic uses only synced values.
- Per-button FSM: identical, independent instances for next and clear; cnt is CNT_W bits.
  - IDLE: sync=1 -> PRESS_WAIT, cnt=0. Otherwise stay.
  - PRESS_WAIT: sync=0 -> IDLE (bounce rejected, no pulse). sync=1 and cnt==DB_CYCLES-1 -> PRESSED, pulse register set. Otherwise cnt+1.
  - PRESSED: sync=0 -> RELEASE_WAIT, cnt=0. Otherwise stay.
  - RELEASE_WAIT: sync=1 -> PRESSED with no new pulse. sync=0 and cnt==DB_CYCLES-1 -> IDLE. Otherwise cnt+1.
- Pulse output: the pulse is a registered output. It is high for exactly the one cycle following the PRESS_WAIT->PRESSED transition and is never high on two consecutive cycles. Holding the button produces no further pulses.
- next_level: high in PRESSED and RELEASE_WAIT, low in IDLE and PRESS_WAIT.
- Latency: raw rises just before edge 1 and stays high. PRESS_WAIT is entered at edge 3. The pulse goes high after edge DB_CYCLES+3 and low after edge DB_CYCLES+4.
- Mode switches:
  - Synced 3-bit value is compared to a candidate register.
  - Mismatch: candidate loads the synced value and the mode counter is cleared to 0.
  - Match and candidate != MS_db: counter increments; when counter==DB_CYCLES-1, MS_db loads candidate.
  - Any change in any bit restarts the count. MS_db only ever shows values held stable for DB_CYCLES cycles and never shows an intermediate mixed value.
- Simultaneous events: next and clear are fully independent, and both pulses may assert in the same cycle. Switch changes do not affect button logic.
- Counter wrap: counters never wrap. They saturate by state transition at DB_CYCLES-1 and are cleared on every restart.
- Reset mid-operation: any state returns to IDLE immediately and an in-flight pulse is dropped. A button held through reset release produces one pulse at full latency, because sync restarts from 0.

Test Plan:
- DB_CYCLES=4, reset, then btn_next_raw 0->1 held -> next_pulse high exactly 1 cycle after edge 7, next_level high from edge 7, no second pulse while held 50 cycles.
- DB_CYCLES=4, btn_next_raw toggles 1,0,1,0 every 2 cycles then settles 1 -> bounce rejected, single next_pulse at 7 edges after the final rise.
- DB_CYCLES=4, next held, release with a 2-cycle glitch back to 1 during release, then 0 -> no extra pulse; next_level falls 7 edges after final fall.
- DB_CYCLES=4, btn_next_raw and btn_clear_raw rise on same cycle -> next_pulse and clear_pulse high on the same single cycle.
- DB_CYCLES=4, sw_ms_raw 000->011 with one-cycle 001 glitch -> MS_db goes straight 000->011, never 001; update 7 edges after last change.
- DB_CYCLES=4, assert clear_n low while next in PRESS_WAIT with button held, release clear_n after 3 cycles -> outputs 0 during reset, then exactly one next_pulse 7 edges after release.

Source files
------------

// File: rtl/button_conditioner.sv
// button_conditioner: synchronises and debounces the raw push-buttons and the
// mode switch bank, producing one-cycle press pulses, a debounced button
// level, and a mode value that only changes once the switches have settled.

// Per-button debounce FSM.
//   state        | meaning
//   IDLE         | button released and accepted as released
//   PRESS_WAIT   | sync went high, counting stable-high cycles
//   PRESSED      | press accepted, pulse already issued
//   RELEASE_WAIT | sync went low, counting stable-low cycles
module button_debounce #(
  parameter int DB_CYCLES = 1000000,
  parameter int CNT_W     = $clog2(DB_CYCLES)
) (
  input  logic CLK,
  input  logic clear_n,
  input  logic sync,
  output logic pulse,
  output logic level
);

  localparam logic [1:0] IDLE         = 2'd0;
  localparam logic [1:0] PRESS_WAIT   = 2'd1;
  localparam logic [1:0] PRESSED      = 2'd2;
  localparam logic [1:0] RELEASE_WAIT = 2'd3;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pulse_d;

  // Next-state, counter and pulse decode; counters restart on every entry
  // into a wait state and stop at CNT_MAX by leaving that state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (sync) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!sync) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_MAX) begin
          state_d = PRESSED;
          pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PRESSED: begin
        if (!sync) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (sync) begin
          state_d = PRESSED;
        end else if (cnt_q == CNT_MAX) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter and registered pulse; reset drops any in-flight pulse.
  always_ff @(posedge CLK or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pulse   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse   <= pulse_d;
    end
  end

  // The button counts as down once accepted, until the release is accepted.
  always_comb begin
    level = (state_q == PRESSED) || (state_q == RELEASE_WAIT);
  end

endmodule

module button_conditioner #(
  parameter int DB_CYCLES = 1000000
) (
  input  logic       CLK,
  input  logic       clear_n,
  input  logic       btn_next_raw,
  input  logic       btn_clear_raw,
  input  logic [2:0] sw_ms_raw,
  output logic       next_pulse,
  output logic       clear_pulse,
  output logic       next_level,
  output logic [2:0] MS_db
);

  localparam int CNT_W = $clog2(DB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

  // Bit order: {sw_ms[2:0], clear, next}.
  logic [4:0] meta_q, sync_q;
  logic [2:0] ms_sync;
  logic [2:0] cand_q;
  logic [CNT_W-1:0] mode_cnt_q;
  logic clear_level;

  // Two-flop synchroniser for every raw input.
  always_ff @(posedge CLK or negedge clear_n) begin
    if (!clear_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= {sw_ms_raw, btn_clear_raw, btn_next_raw};
      sync_q <= meta_q;
    end
  end

  assign ms_sync = sync_q[4:2];

  button_debounce #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_next (
    .CLK     (CLK),
    .clear_n (clear_n),
    .sync    (sync_q[0]),
    .pulse   (next_pulse),
    .level   (next_level)
  );

  button_debounce #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_clear (
    .CLK     (CLK),
    .clear_n (clear_n),
    .sync    (sync_q[1]),
    .pulse   (clear_pulse),
    .level   (clear_level)
  );

  // Mode filter: the whole 3-bit word is tracked as one candidate, so any bit
  // change restarts the count and MS_db never shows a mixed value.
  always_ff @(posedge CLK or negedge clear_n) begin
    if (!clear_n) begin
      cand_q     <= 3'b000;
      mode_cnt_q <= '0;
      MS_db      <= 3'b000;
    end else if (ms_sync != cand_q) begin
      cand_q     <= ms_sync;
      mode_cnt_q <= '0;
    end else if (cand_q != MS_db) begin
      if (mode_cnt_q == CNT_MAX) begin
        MS_db      <= cand_q;
        mode_cnt_q <= '0;
      end else begin
        mode_cnt_q <= mode_cnt_q + 1'b1;
      end
    end
  end

  // The clear level has no consumer; fold it in so it is visibly used.
  logic unused_ok;
  assign unused_ok = clear_level;

endmodule
